// File: rtl/ef_sms_enc8.sv
// ef_sms_enc8 -- 8-bit segmented mismatch-shaping encoder for the smsdac8 DAC.
//
// The code splits into a 3-bit MSB segment, steered through a 3-level tree of
// switching blocks onto 8 equal-weight (32 LSB) unit elements, and a 5-bit
// binary LSB segment carried alongside it. One tree level per pipeline stage.
//
// Build option: define EF_SMS_SHAPING_EN for first-order mismatch shaping
// (per-block accumulator state). Left undefined, each block randomises odd
// splits from its random bit alone (plain DEM); timing is identical.
//
// Ports (ef_sms_enc8):
//   i_clk    in   1   clock
//   i_rst_b  in   1   asynchronous active-low reset
//   i_en     in   1   sample enable; all state holds while low
//   i_code   in   8   unsigned DAC code
//   i_r      in  11   random bits; [6:0] used, [10:7] ignored
//   o_msb    out  8   unit-element enables, weight 32 each
//   o_lsb    out  5   binary LSB bits, delay-matched to o_msb
//   o_valid  out  1   high once 3 enabled samples have entered since reset
//
// Ports (ef_sms_sb, one switching block):
//   clk_i, rst_b_i, en_i   accumulator clocking (shaping build only)
//   v_i    in  WI   block input value
//   r_i    in   1   random bit for odd splits
//   top_o  out WO   (v+s)/2, drives the higher-index half
//   bot_o  out WO   (v-s)/2, drives the lower-index half

// Switching block: splits v into top/bot, differing by at most one.
module ef_sms_sb #(
   parameter int unsigned WI = 3,
   parameter int unsigned WO = 3
) (
`ifdef EF_SMS_SHAPING_EN
   input  logic          clk_i,
   input  logic          rst_b_i,
   input  logic          en_i,
`endif
   input  logic [WI-1:0] v_i,
   input  logic          r_i,
   output logic [WO-1:0] top_o,
   output logic [WO-1:0] bot_o
);

   logic          odd_c;
   logic          pos_c;    // 1: s = +1 (extra unit to top), 0: s = -1
   logic [WI-2:0] half_c;

   assign odd_c  = v_i[0];
   assign half_c = v_i[WI-1:1];

`ifdef EF_SMS_SHAPING_EN
   // acc encoding: 00 = 0, 01 = +1, 11 = -1 (two's complement)
   localparam logic [1:0] ACC_ZERO = 2'b00;
   localparam logic [1:0] ACC_POS  = 2'b01;
   localparam logic [1:0] ACC_NEG  = 2'b11;

   logic [1:0] acc_q;
   logic [1:0] acc_d;

   // Nonzero acc forces s = -acc, so acc always returns to 0 on the next odd sample.
   always_comb begin
      acc_d = acc_q;
      pos_c = (acc_q == ACC_ZERO) ? r_i : acc_q[1];
      if (odd_c) begin
         acc_d = (acc_q == ACC_ZERO) ? (r_i ? ACC_POS : ACC_NEG) : ACC_ZERO;
      end
   end

   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         acc_q <= ACC_ZERO;
      end else if (en_i) begin
         acc_q <= acc_d;
      end
   end
`else
   assign pos_c = r_i;
`endif

   assign top_o = WO'(half_c) + WO'(odd_c & pos_c);
   assign bot_o = WO'(half_c) + WO'(odd_c & ~pos_c);

endmodule

// Encoder top: 3-stage tree pipeline with delay-matched LSB path.
module ef_sms_enc8 (
   input  logic        i_clk,
   input  logic        i_rst_b,
   input  logic        i_en,
   input  logic [7:0]  i_code,
   input  logic [10:0] i_r,
   output logic [7:0]  o_msb,
   output logic [4:0]  o_lsb,
   output logic        o_valid
);

   localparam int unsigned L1_W  = 3;   // L1 outputs span 0..4
   localparam int unsigned L2_W  = 2;   // L2 outputs span 0..2
   localparam int unsigned LSB_W = 5;

   logic [L1_W-1:0]       l1_top_d, l1_bot_d;
   logic [L1_W-1:0]       s1_top_q, s1_bot_q;
   logic [LSB_W-1:0]      s1_lsb_q;

   // Quarter order: [3] = hi.top (elements 7,6) ... [0] = lo.bot (elements 1,0)
   logic [3:0][L2_W-1:0]  s2_d;
   logic [3:0][L2_W-1:0]  s2_q;
   logic [LSB_W-1:0]      s2_lsb_q;

   logic [7:0]            msb_d;
   logic [7:0]            msb_q;
   logic [LSB_W-1:0]      lsb_q;
   logic [2:0]            vld_q;

   logic                  unused_r;
   assign unused_r = ^i_r[10:7];

   // Level 1: MSB segment into upper/lower halves.
   ef_sms_sb #(.WI(L1_W), .WO(L1_W)) u_sb_l1 (
`ifdef EF_SMS_SHAPING_EN
      .clk_i   (i_clk),
      .rst_b_i (i_rst_b),
      .en_i    (i_en),
`endif
      .v_i     (i_code[7:5]),
      .r_i     (i_r[0]),
      .top_o   (l1_top_d),
      .bot_o   (l1_bot_d)
   );

   // Level 2: each half into quarters.
   ef_sms_sb #(.WI(L1_W), .WO(L2_W)) u_sb_l2_hi (
`ifdef EF_SMS_SHAPING_EN
      .clk_i   (i_clk),
      .rst_b_i (i_rst_b),
      .en_i    (i_en),
`endif
      .v_i     (s1_top_q),
      .r_i     (i_r[2]),
      .top_o   (s2_d[3]),
      .bot_o   (s2_d[2])
   );

   ef_sms_sb #(.WI(L1_W), .WO(L2_W)) u_sb_l2_lo (
`ifdef EF_SMS_SHAPING_EN
      .clk_i   (i_clk),
      .rst_b_i (i_rst_b),
      .en_i    (i_en),
`endif
      .v_i     (s1_bot_q),
      .r_i     (i_r[1]),
      .top_o   (s2_d[1]),
      .bot_o   (s2_d[0])
   );

   // Level 3: quarter j onto element pair {2j+1, 2j}.
   for (genvar j = 0; j < 4; j++) begin : g_l3
      ef_sms_sb #(.WI(L2_W), .WO(1)) u_sb_l3 (
`ifdef EF_SMS_SHAPING_EN
         .clk_i   (i_clk),
         .rst_b_i (i_rst_b),
         .en_i    (i_en),
`endif
         .v_i     (s2_q[j]),
         .r_i     (i_r[3+j]),
         .top_o   (msb_d[2*j+1]),
         .bot_o   (msb_d[2*j])
      );
   end

   // Pipeline registers, advancing only on enabled edges.
   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         s1_top_q <= '0;
         s1_bot_q <= '0;
         s1_lsb_q <= '0;
         s2_q     <= '0;
         s2_lsb_q <= '0;
         msb_q    <= '0;
         lsb_q    <= '0;
         vld_q    <= '0;
      end else if (i_en) begin
         s1_top_q <= l1_top_d;
         s1_bot_q <= l1_bot_d;
         s1_lsb_q <= i_code[4:0];
         s2_q     <= s2_d;
         s2_lsb_q <= s1_lsb_q;
         msb_q    <= msb_d;
         lsb_q    <= s2_lsb_q;
         vld_q    <= {vld_q[1:0], 1'b1};
      end
   end

   assign o_msb   = msb_q;
   assign o_lsb   = lsb_q;
   assign o_valid = vld_q[2];

endmodule
